// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring divider, signed or unsigned.
// One trial subtraction per clock. Every operation takes a fixed WIDTH+1
// edges from the accepting edge to the done pulse, special cases included.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   start_i      request a division (sampled only while busy_o = 0)
//   signed_i     1 = two's-complement operands (sampled with start_i)
//   dividend_i   dividend (sampled with start_i)
//   divisor_i    divisor (sampled with start_i)
//   flush_i      abort the operation in progress, no done pulse
//   busy_o       operation in progress
//   done_o       one-cycle pulse, results valid from this cycle on
//   quotient_o   registered quotient, held until the next completion
//   remainder_o  registered remainder, held until the next completion
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CW-1:0]    count_r;
  logic [WIDTH:0]   rem_r;       // partial remainder, one guard bit wide
  logic [WIDTH-1:0] dq_r;        // dividend shifts out the top, quotient in the bottom
  logic [WIDTH-1:0] dvsr_r;      // divisor magnitude
  logic             q_neg_r;
  logic             r_neg_r;
  logic             div_zero_r;
  logic             ovf_r;

  logic [WIDTH:0]   shift_s;
  logic [WIDTH:0]   diff_s;
  logic             q_bit_s;
  logic             last_s;
  logic             dvd_neg_s;
  logic             dvs_neg_s;
  logic [WIDTH-1:0] q_fix_s;
  logic [WIDTH-1:0] r_fix_s;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; flush wins over completion in FIX (both go to IDLE).
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_i) state_s = CALC;
        else         state_s = IDLE;
      end
      CALC: begin
        if (flush_i)     state_s = IDLE;
        else if (last_s) state_s = FIX;
        else             state_s = CALC;
      end
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Operand signs, one restoring iteration, and the final sign/special-case fixup.
  always_comb begin
    dvd_neg_s = signed_i & dividend_i[WIDTH-1];
    dvs_neg_s = signed_i & divisor_i[WIDTH-1];
    last_s    = (count_r == CW'(WIDTH - 1));
    shift_s   = {rem_r[WIDTH-1:0], dq_r[WIDTH-1]};
    // rem_r < divisor, so the difference always fits WIDTH+1 bits and its
    // top bit is a true sign.
    diff_s    = shift_s - {1'b0, dvsr_r};
    q_bit_s   = ~diff_s[WIDTH];
    if (div_zero_r) begin
      // Dividing by zero leaves |dividend| in the remainder; restoring its
      // sign reproduces the original dividend bit pattern.
      q_fix_s = ALL_ONES;
      r_fix_s = r_neg_r ? negate(rem_r[WIDTH-1:0]) : rem_r[WIDTH-1:0];
    end else if (ovf_r) begin
      q_fix_s = MOST_NEG;
      r_fix_s = ZERO;
    end else begin
      q_fix_s = q_neg_r ? negate(dq_r) : dq_r;
      r_fix_s = r_neg_r ? negate(rem_r[WIDTH-1:0]) : rem_r[WIDTH-1:0];
    end
  end

  // Datapath, handshake and result registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_r     <= {CW{1'b0}};
      rem_r       <= {(WIDTH+1){1'b0}};
      dq_r        <= ZERO;
      dvsr_r      <= ZERO;
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
      div_zero_r  <= 1'b0;
      ovf_r       <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      quotient_o  <= ZERO;
      remainder_o <= ZERO;
    end else begin
      done_o <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_i) begin
            dq_r       <= dvd_neg_s ? negate(dividend_i) : dividend_i;
            dvsr_r     <= dvs_neg_s ? negate(divisor_i) : divisor_i;
            q_neg_r    <= dvd_neg_s ^ dvs_neg_s;
            r_neg_r    <= dvd_neg_s;
            div_zero_r <= (divisor_i == ZERO);
            ovf_r      <= signed_i && (dividend_i == MOST_NEG) && (divisor_i == ALL_ONES);
            rem_r      <= {(WIDTH+1){1'b0}};
            count_r    <= {CW{1'b0}};
            busy_o     <= 1'b1;
          end else begin
            busy_o <= 1'b0;
          end
        end
        CALC: begin
          if (flush_i) begin
            busy_o <= 1'b0;
          end else begin
            rem_r   <= q_bit_s ? diff_s : shift_s;
            dq_r    <= {dq_r[WIDTH-2:0], q_bit_s};
            count_r <= last_s ? {CW{1'b0}} : count_r + CW'(1);
          end
        end
        FIX: begin
          busy_o <= 1'b0;
          if (!flush_i) begin
            quotient_o  <= q_fix_s;
            remainder_o <= r_fix_s;
            done_o      <= 1'b1;
          end
        end
        default: begin
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
